// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared constants and types for the 1-to-9 stream demultiplexer.
//   DEMUX_NUM_CH  number of output channels (fixed at 9)
//   DEMUX_SEL_W   select width, 2**DEMUX_SEL_W >= DEMUX_NUM_CH
//   DEMUX_DATA_W  data word width
//   demux_word_t  one data word
package demux_pkg;

  localparam int DEMUX_NUM_CH = 9;
  localparam int DEMUX_SEL_W  = 4;
  localparam int DEMUX_DATA_W = 16;

  typedef logic [DEMUX_DATA_W-1:0] demux_word_t;

endpackage

// File: rtl/demux_ch_reg.sv
// demux_ch_reg
//   One-entry valid/ready output register for a single demux channel.
//   A load always wins. If the consumer takes the current word in the same
//   cycle, the register is refilled and valid stays high.
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   load   in   capture din this cycle
//   din    in   word to capture
//   ready  in   consumer ready
//   data   out  held word
//   valid  out  held word is valid
module demux_ch_reg
  import demux_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  demux_word_t din,
  input  logic        ready,
  output demux_word_t data,
  output logic        valid
);

  // When no load occurs, data keeps its last value after the word is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to9_stream.sv
// demux_1to9_stream
//   Routes one input word stream to one of nine output channels, chosen per
//   word by s_sel. Each channel has its own one-entry register. Words with a
//   select outside 0..8 are consumed, dropped and flagged in err.
//   Optional macro DEMUX_DROP_CNT_EN builds a saturating counter of dropped
//   words. Without the macro, drop_cnt is tied to zero.
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   s_data     in   input word
//   s_sel      in   destination channel
//   s_valid    in   input word valid
//   s_ready    out  input word accepted when s_valid && s_ready
//   out_data   out  channel k at [k*DATA_W +: DATA_W]
//   out_valid  out  per-channel valid
//   out_ready  in   per-channel consumer ready
//   err        out  sticky flag: an invalid select was dropped
//   err_clr    in   synchronous clear of err (and of drop_cnt)
//   drop_cnt   out  saturating count of dropped words
module demux_1to9_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int NUM_CH = DEMUX_NUM_CH,
  parameter int SEL_W  = DEMUX_SEL_W,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     err,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int SEL_RANGE = 2**SEL_W;
  localparam logic [SEL_W-1:0] NUM_CH_SEL = SEL_W'(NUM_CH);

  logic [NUM_CH-1:0]    free;
  logic [SEL_RANGE-1:0] free_ext;
  logic                 sel_ok;
  logic                 accept;
  logic                 drop;

  // A channel can take a word if it is empty or its word leaves this cycle.
  // The free vector is padded to the full select range so that out-of-range
  // selects index a defined bit. Those bits are masked by sel_ok.
  assign free     = ~out_valid | out_ready;
  assign free_ext = {{(SEL_RANGE-NUM_CH){1'b0}}, free};
  assign sel_ok   = (s_sel < NUM_CH_SEL);
  assign s_ready  = sel_ok ? free_ext[s_sel] : 1'b1;
  assign accept   = s_valid && s_ready;
  assign drop     = accept && !sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_ch_reg u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (accept && (s_sel == SEL_W'(k))),
      .din   (s_data),
      .ready (out_ready[k]),
      .data  (out_data[k*DATA_W +: DATA_W]),
      .valid (out_valid[k])
    );
  end

  // Setting the error flag takes priority over clearing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] cnt;

  // A drop together with err_clr restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (drop) begin
      if (err_clr) begin
        cnt <= CNT_W'(1);
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      cnt <= '0;
    end
  end

  assign drop_cnt = cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1to9_stream.sv
// tb_demux_1to9_stream
//   Self-checking bench for demux_1to9_stream. A behavioural model tracks
//   per-channel contents, err and the drop count. Every DUT output is compared
//   against that model. Define DEMUX_DROP_CNT_EN to exercise the drop counter.
module tb_demux_1to9_stream;

  localparam int NCH = 9;
  localparam int DW  = 16;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     s_data;
  logic [3:0]        s_sel;
  logic              s_valid;
  logic              s_ready;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic              err;
  logic              err_clr;
  logic [7:0]        drop_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: one slot per channel, plus the error flag and the drop counter.
  logic          mv [NCH];
  logic [DW-1:0] md [NCH];
  logic          m_err;
  int            m_cnt;

  demux_1to9_stream dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_sel     (s_sel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic checkOutput(input string tag);
    logic [NCH-1:0]    ev;
    logic [NCH*DW-1:0] ed;
    logic [7:0]        ec;
    for (int k = 0; k < NCH; k++) begin
      ev[k] = mv[k];
      ed[k*DW +: DW] = md[k];
    end
    ec = 8'(m_cnt);
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("[TB] FAIL %s out_valid got=%h exp=%h", tag, out_valid, ev);
    end
    checks++;
    assert (out_data === ed) else begin
      errors++;
      $error("[TB] FAIL %s out_data got=%h exp=%h", tag, out_data, ed);
    end
    checks++;
    assert (err === m_err) else begin
      errors++;
      $error("[TB] FAIL %s err got=%b exp=%b", tag, err, m_err);
    end
    checks++;
    assert (drop_cnt === ec) else begin
      errors++;
      $error("[TB] FAIL %s drop_cnt got=%0d exp=%0d", tag, drop_cnt, ec);
    end
  endtask

  // Drives one cycle of inputs, checks s_ready before the edge, advances the
  // model at the edge and checks the registered outputs after it.
  task automatic applyStimulus(input string tag, input logic [3:0] sel,
                               input logic [DW-1:0] data, input logic valid,
                               input logic [NCH-1:0] rdy, input logic clr);
    logic exp_ready;
    logic acc;
    logic drp;
    s_sel     = sel;
    s_data    = data;
    s_valid   = valid;
    out_ready = rdy;
    err_clr   = clr;
    #1;
    exp_ready = (sel < 4'(NCH)) ? (!mv[sel] || rdy[sel]) : 1'b1;
    checks++;
    assert (s_ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL %s s_ready got=%b exp=%b", tag, s_ready, exp_ready);
    end
    @(posedge clk);
    acc = valid && exp_ready;
    drp = acc && (sel >= 4'(NCH));
    for (int k = 0; k < NCH; k++) begin
      if (acc && (int'(sel) == k)) begin
        mv[k] = 1'b1;
        md[k] = data;
      end else if (rdy[k]) begin
        mv[k] = 1'b0;
      end
    end
    if (drp) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
    if (drp) m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
    else if (clr) m_cnt = 0;
`endif
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [NCH-1:0] all1;
    all1 = '1;
    rst = 1'b1;
    s_sel = '0;
    s_data = '0;
    s_valid = 1'b0;
    out_ready = '0;
    err_clr = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    checks++;
    assert (s_ready === 1'b1) else begin
      errors++;
      $error("[TB] FAIL reset s_ready got=%b exp=1", s_ready);
    end
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word to channel 3, then it drains.
    applyStimulus("t1_send", 4'd3, 16'hA5A5, 1'b1, all1, 1'b0);
    checks++;
    assert (out_valid === 9'h008 && out_data[3*DW +: DW] === 16'hA5A5) else begin
      errors++;
      $error("[TB] FAIL t1_ch3 got=%h/%h exp=008/a5a5", out_valid, out_data[3*DW +: DW]);
    end
    applyStimulus("t1_drain", 4'd3, 16'h0000, 1'b0, all1, 1'b0);

    // Stall channel 5 while channel 0 keeps flowing.
    applyStimulus("t2_w1", 4'd5, 16'h1111, 1'b1, 9'h1DF, 1'b0);
    applyStimulus("t2_w2_blk", 4'd5, 16'h2222, 1'b1, 9'h1DF, 1'b0);
    applyStimulus("t2_ch0", 4'd0, 16'h3333, 1'b1, 9'h1DF, 1'b0);
    checks++;
    assert (out_data[5*DW +: DW] === 16'h1111) else begin
      errors++;
      $error("[TB] FAIL t2_hold got=%h exp=1111", out_data[5*DW +: DW]);
    end
    applyStimulus("t2_w2_go", 4'd5, 16'h2222, 1'b1, all1, 1'b0);
    applyStimulus("t2_drain", 4'd0, 16'h0000, 1'b0, all1, 1'b0);

    // Back-to-back stream to channel 8.
    for (int i = 0; i < 16; i++) begin
      applyStimulus("t3_stream", 4'd8, 16'(16'hC000 + i * 7), 1'b1, all1, 1'b0);
    end
    applyStimulus("t3_drain", 4'd8, 16'h0000, 1'b0, all1, 1'b0);

    // Invalid selects, then a drop coinciding with err_clr.
    applyStimulus("t4_sel9", 4'd9, 16'hDEAD, 1'b1, all1, 1'b0);
    applyStimulus("t4_sel15", 4'd15, 16'hBEEF, 1'b1, all1, 1'b0);
    checks++;
    assert (err === 1'b1) else begin
      errors++;
      $error("[TB] FAIL t4_err got=%b exp=1", err);
    end
    applyStimulus("t4_drop_clr", 4'd12, 16'h0BAD, 1'b1, all1, 1'b1);
    applyStimulus("t4_clr", 4'd0, 16'h0000, 1'b0, all1, 1'b1);

    // Saturation of the drop counter (stays zero without the counter).
    for (int i = 0; i < 300; i++) begin
      applyStimulus("t5_sat", 4'(9 + (i % 7)), 16'(i), 1'b1, all1, 1'b0);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    assert (drop_cnt === 8'hFF) else begin
      errors++;
      $error("[TB] FAIL t5_sat_val got=%0d exp=255", drop_cnt);
    end
`else
    checks++;
    assert (drop_cnt === 8'h00) else begin
      errors++;
      $error("[TB] FAIL t5_zero got=%0d exp=0", drop_cnt);
    end
`endif

    // Mid-transfer reset: ch2 holds a word, ch7 is stalled.
    applyStimulus("t6_ch2", 4'd2, 16'h2A2A, 1'b1, 9'h07B, 1'b0);
    applyStimulus("t6_ch7", 4'd7, 16'h7B7B, 1'b1, 9'h07B, 1'b0);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("t6_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    applyStimulus("t6_resume", 4'd4, 16'h4444, 1'b1, all1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 9'($urandom),
                    1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
